// File: rtl/gpi_event_unit.sv
//-----------------------------------------------------------------------------
// gpi_event_unit
//
// Multi-channel push-button / switch front end. Each channel is handled
// independently:
//   raw input -> 2-flop synchroniser -> polarity normalise (pressed = 1)
//   -> debounce -> press classifier FSM (IDLE / HELD / LONG)
//   -> one-cycle event pulses, sticky pending flags, long-press toggle bit.
//
// Ports:
//   clk            system clock
//   resetn         asynchronous active-low reset
//   btn_i          [NUM_CH] raw asynchronous button/switch inputs
//   ev_ack_i       [NUM_CH] acknowledge, clears that channel's pending flags
//   level_o        [NUM_CH] debounced pressed level (1 = pressed)
//   press_pulse_o  [NUM_CH] one-cycle pulse on a debounced press
//   short_pulse_o  [NUM_CH] one-cycle pulse on release before the threshold
//   long_pulse_o   [NUM_CH] one-cycle pulse when the hold reaches LONG_CNT
//   short_pend_o   [NUM_CH] sticky short-press flag
//   long_pend_o    [NUM_CH] sticky long-press flag
//   toggle_o       [NUM_CH] flips on every long pulse
//
// Timing (clean input):
//   raw edge -> level_o change        : 2 + DEB_CNT cycles
//   level_o rise -> press_pulse_o     : 1 cycle
//   press_pulse_o -> long_pulse_o     : LONG_CNT cycles
//   event pulse -> pending flag set   : 1 cycle (a coincident ack loses)
//
// Build option:
//   GPI_EVENT_UNIT_AUTOREPEAT_EN - when defined, a channel in LONG re-issues
//   press_pulse_o every REP_CNT cycles (first one REP_CNT cycles after
//   long_pulse_o) until release. Pending flags are not touched by repeats.
//   When undefined, REPEAT_ns has no effect.
//-----------------------------------------------------------------------------
module gpi_event_unit #(
    parameter int NUM_CH            = 4,
    parameter int CLK_PERIOD_ns     = 20,
    parameter int DEBOUNCE_TIMER_ns = 30_000_000,
    parameter int LONG_PRESS_ns     = 2_000_000_000,
    parameter int REPEAT_ns         = 200_000_000,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NUM_CH-1:0] btn_i,
    input  logic [NUM_CH-1:0] ev_ack_i,
    output logic [NUM_CH-1:0] level_o,
    output logic [NUM_CH-1:0] press_pulse_o,
    output logic [NUM_CH-1:0] short_pulse_o,
    output logic [NUM_CH-1:0] long_pulse_o,
    output logic [NUM_CH-1:0] short_pend_o,
    output logic [NUM_CH-1:0] long_pend_o,
    output logic [NUM_CH-1:0] toggle_o
);

    // Cycle counts derived from the time parameters, never below one cycle.
    localparam int DEB_RAW  = DEBOUNCE_TIMER_ns / CLK_PERIOD_ns;
    localparam int DEB_CNT  = (DEB_RAW < 1) ? 1 : DEB_RAW;
    localparam int DEB_W    = $clog2(DEB_CNT + 1);

    localparam int LONG_RAW = LONG_PRESS_ns / CLK_PERIOD_ns;
    localparam int LONG_CNT = (LONG_RAW < 1) ? 1 : LONG_RAW;
    localparam int HOLD_W   = $clog2(LONG_CNT + 1);

`ifdef GPI_EVENT_UNIT_AUTOREPEAT_EN
    localparam int REP_RAW  = REPEAT_ns / CLK_PERIOD_ns;
    localparam int REP_CNT  = (REP_RAW < 1) ? 1 : REP_RAW;
    localparam int REP_W    = $clog2(REP_CNT + 1);
`endif

    // Raw input level that means "not pressed"; synchronisers reset to it so
    // a button held through reset is seen as a fresh press afterwards.
    localparam logic RAW_RELEASED = ACTIVE_LOW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } state_e;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch

        //---------------------------------------------------------------------
        // Synchroniser and polarity normalisation
        //---------------------------------------------------------------------
        logic sync1_q;
        logic sync2_q;
        logic pressed_sync;

        // NOTE: clocked state is always written with non-blocking (<=)
        // assignments so every flop samples pre-edge values and the
        // two-stage synchroniser really is two stages.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                sync1_q <= RAW_RELEASED;
                sync2_q <= RAW_RELEASED;
            end else begin
                sync1_q <= btn_i[ch];
                sync2_q <= sync1_q;
            end
        end

        assign pressed_sync = sync2_q ^ ACTIVE_LOW;

        //---------------------------------------------------------------------
        // Debounce: the synced value must disagree with the stable value for
        // DEB_CNT consecutive cycles before it is accepted. Any agreeing
        // cycle restarts the count, so short glitches are discarded.
        //---------------------------------------------------------------------
        logic [DEB_W-1:0] deb_cnt_q;
        logic             stable_q;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                deb_cnt_q <= '0;
                stable_q  <= 1'b0;
            end else if (pressed_sync == stable_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DEB_W'(DEB_CNT - 1)) begin
                stable_q  <= pressed_sync;
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + DEB_W'(1);
            end
        end

        //---------------------------------------------------------------------
        // Press classifier. The FSM works on the debounced level: in IDLE a
        // high level can only mean a new press, in HELD/LONG a low level can
        // only mean a release. Release is tested before the threshold so a
        // coincident release is reported as a short press.
        //---------------------------------------------------------------------
        state_e            state_q;
        state_e            state_d;
        logic [HOLD_W-1:0] hold_cnt_q;
        logic [HOLD_W-1:0] hold_cnt_d;
        logic              press_d;
        logic              short_d;
        logic              long_d;
`ifdef GPI_EVENT_UNIT_AUTOREPEAT_EN
        logic [REP_W-1:0]  rep_cnt_q;
        logic [REP_W-1:0]  rep_cnt_d;
`endif

        always_comb begin
            // NOTE: every signal driven here gets a default before the case,
            // so no path leaves it unassigned and no latch is inferred.
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            press_d    = 1'b0;
            short_d    = 1'b0;
            long_d     = 1'b0;
`ifdef GPI_EVENT_UNIT_AUTOREPEAT_EN
            rep_cnt_d  = rep_cnt_q;
`endif
            unique case (state_q)
                ST_IDLE: begin
                    if (stable_q) begin
                        state_d    = ST_HELD;
                        hold_cnt_d = '0;
                        press_d    = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!stable_q) begin
                        state_d = ST_IDLE;
                        short_d = 1'b1;
                    end else if (hold_cnt_q == HOLD_W'(LONG_CNT - 1)) begin
                        // Counter parks at LONG_CNT for the rest of the hold.
                        state_d    = ST_LONG;
                        hold_cnt_d = HOLD_W'(LONG_CNT);
                        long_d     = 1'b1;
`ifdef GPI_EVENT_UNIT_AUTOREPEAT_EN
                        rep_cnt_d  = '0;
`endif
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                ST_LONG: begin
                    if (!stable_q) begin
                        state_d   = ST_IDLE;
`ifdef GPI_EVENT_UNIT_AUTOREPEAT_EN
                        rep_cnt_d = '0;
                    end else if (rep_cnt_q == REP_W'(REP_CNT - 1)) begin
                        press_d   = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
`endif
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        //---------------------------------------------------------------------
        // State, registered pulses, toggle and sticky flags. A flag is set
        // from the already-registered pulse, so an ack arriving in the pulse
        // cycle is overridden by the set.
        //---------------------------------------------------------------------
        logic press_q;
        logic short_q;
        logic long_q;
        logic toggle_q;
        logic short_pend_q;
        logic long_pend_q;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state_q      <= ST_IDLE;
                hold_cnt_q   <= '0;
                press_q      <= 1'b0;
                short_q      <= 1'b0;
                long_q       <= 1'b0;
                toggle_q     <= 1'b0;
                short_pend_q <= 1'b0;
                long_pend_q  <= 1'b0;
            end else begin
                state_q      <= state_d;
                hold_cnt_q   <= hold_cnt_d;
                press_q      <= press_d;
                short_q      <= short_d;
                long_q       <= long_d;
                toggle_q     <= toggle_q ^ long_d;
                short_pend_q <= short_q | (short_pend_q & ~ev_ack_i[ch]);
                long_pend_q  <= long_q  | (long_pend_q  & ~ev_ack_i[ch]);
            end
        end

`ifdef GPI_EVENT_UNIT_AUTOREPEAT_EN
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                rep_cnt_q <= '0;
            end else begin
                rep_cnt_q <= rep_cnt_d;
            end
        end
`endif

        assign level_o[ch]       = stable_q;
        assign press_pulse_o[ch] = press_q;
        assign short_pulse_o[ch] = short_q;
        assign long_pulse_o[ch]  = long_q;
        assign short_pend_o[ch]  = short_pend_q;
        assign long_pend_o[ch]   = long_pend_q;
        assign toggle_o[ch]      = toggle_q;

    end : g_ch

endmodule

// File: tb/tb_gpi_event_unit.sv
//-----------------------------------------------------------------------------
// tb_gpi_event_unit
//
// Directed bench for gpi_event_unit with DEB_CNT = 5, LONG_CNT = 50,
// REP_CNT = 10, ACTIVE_LOW = 1, NUM_CH = 4. Inputs are driven and outputs
// sampled 1 ns after the rising edge; a negedge monitor counts pulses per
// channel and records the cycle index of the latest one.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_gpi_event_unit;

    localparam int NUM_CH = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NUM_CH-1:0] btn_i;
    logic [NUM_CH-1:0] ev_ack_i;
    logic [NUM_CH-1:0] level_o;
    logic [NUM_CH-1:0] press_pulse_o;
    logic [NUM_CH-1:0] short_pulse_o;
    logic [NUM_CH-1:0] long_pulse_o;
    logic [NUM_CH-1:0] short_pend_o;
    logic [NUM_CH-1:0] long_pend_o;
    logic [NUM_CH-1:0] toggle_o;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int press_cnt [NUM_CH] = '{default: 0};
    int short_cnt [NUM_CH] = '{default: 0};
    int long_cnt  [NUM_CH] = '{default: 0};
    int press_cyc [NUM_CH] = '{default: 0};
    int long_cyc  [NUM_CH] = '{default: 0};

    gpi_event_unit #(
        .NUM_CH            (NUM_CH),
        .CLK_PERIOD_ns     (20),
        .DEBOUNCE_TIMER_ns (100),
        .LONG_PRESS_ns     (1000),
        .REPEAT_ns         (200),
        .ACTIVE_LOW        (1'b1)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .btn_i         (btn_i),
        .ev_ack_i      (ev_ack_i),
        .level_o       (level_o),
        .press_pulse_o (press_pulse_o),
        .short_pulse_o (short_pulse_o),
        .long_pulse_o  (long_pulse_o),
        .short_pend_o  (short_pend_o),
        .long_pend_o   (long_pend_o),
        .toggle_o      (toggle_o)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (press_pulse_o[c] === 1'b1) begin
                press_cnt[c] <= press_cnt[c] + 1;
                press_cyc[c] <= cyc;
            end
            if (short_pulse_o[c] === 1'b1) begin
                short_cnt[c] <= short_cnt[c] + 1;
            end
            if (long_pulse_o[c] === 1'b1) begin
                long_cnt[c] <= long_cnt[c] + 1;
                long_cyc[c] <= cyc;
            end
        end
    end

    function automatic logic [7*NUM_CH-1:0] all_outs();
        return {level_o, press_pulse_o, short_pulse_o, long_pulse_o,
                short_pend_o, long_pend_o, toggle_o};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    //-------------------------------------------------------------------------
    task automatic test_reset();
        logic [7*NUM_CH-1:0] seen;
        step(3);
        n_assert++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs %h, expected 0", all_outs());
        end
        resetn = 1'b1;
        seen = '0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            seen = seen | all_outs();
        end
        n_assert++;
        if (seen !== '0) begin
            n_fail++;
            $display("FAIL reset_idle_100: OR of outputs %h, expected 0", seen);
        end
        n_assert++;
        if ((press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]) !== 0) begin
            n_fail++;
            $display("FAIL reset_no_press: press pulses counted, expected none");
        end
    endtask

    //-------------------------------------------------------------------------
    task automatic test_glitch();
        logic seen_lvl;
        int   pp;
        pp = press_cnt[0];
        seen_lvl = 1'b0;
        btn_i[0] = 1'b0;
        step(3);
        btn_i[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            seen_lvl = seen_lvl | level_o[0];
        end
        n_assert++;
        if (seen_lvl !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_level: level_o[0] rose, expected to stay 0");
        end
        n_assert++;
        if (press_cnt[0] !== pp) begin
            n_fail++;
            $display("FAIL glitch_press: %0d press pulses, expected %0d", press_cnt[0], pp);
        end
    endtask

    //-------------------------------------------------------------------------
    task automatic test_short_press();
        int pp, sp, lp;
        pp = press_cnt[1];
        sp = short_cnt[1];
        lp = long_cnt[1];
        btn_i[1] = 1'b0;
        step(6);
        n_assert++;
        if (level_o[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL short_level_early: level_o[1]=%b after 6 cycles, expected 0", level_o[1]);
        end
        step(1);
        n_assert++;
        if (level_o[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL short_level_rise: level_o[1]=%b after 7 cycles, expected 1", level_o[1]);
        end
        step(1);
        n_assert++;
        if (press_pulse_o[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL short_press_pulse: press_pulse_o[1]=%b after 8 cycles, expected 1", press_pulse_o[1]);
        end
        step(12);
        btn_i[1] = 1'b1;
        step(8);
        n_assert++;
        if (short_pulse_o[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL short_pulse: short_pulse_o[1]=%b 8 cycles after release, expected 1", short_pulse_o[1]);
        end
        step(1);
        n_assert++;
        if (short_pend_o[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL short_pend_set: short_pend_o[1]=%b, expected 1", short_pend_o[1]);
        end
        step(5);
        n_assert++;
        if (short_pend_o[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL short_pend_sticky: short_pend_o[1]=%b, expected 1", short_pend_o[1]);
        end
        n_assert++;
        if (press_cnt[1] !== pp + 1 || short_cnt[1] !== sp + 1 || long_cnt[1] !== lp) begin
            n_fail++;
            $display("FAIL short_counts: press/short/long +%0d/+%0d/+%0d, expected +1/+1/+0",
                     press_cnt[1] - pp, short_cnt[1] - sp, long_cnt[1] - lp);
        end
        ev_ack_i[1] = 1'b1;
        step(1);
        ev_ack_i[1] = 1'b0;
        n_assert++;
        if (short_pend_o[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL short_pend_ack: short_pend_o[1]=%b after ack, expected 0", short_pend_o[1]);
        end
    endtask

    //-------------------------------------------------------------------------
    task automatic test_long_press();
        int   pp, sp, lp, c0;
        logic exp_tog;
        for (int r = 0; r < 2; r++) begin
            exp_tog = (r == 0) ? 1'b1 : 1'b0;
            pp = press_cnt[2];
            sp = short_cnt[2];
            lp = long_cnt[2];
            c0 = cyc;
            btn_i[2] = 1'b0;
            step(200);
            btn_i[2] = 1'b1;
            step(15);
            n_assert++;
            if (press_cnt[2] !== pp + 1 || long_cnt[2] !== lp + 1 || short_cnt[2] !== sp) begin
                n_fail++;
                $display("FAIL long_counts_%0d: press/short/long +%0d/+%0d/+%0d, expected +1/+0/+1",
                         r, press_cnt[2] - pp, short_cnt[2] - sp, long_cnt[2] - lp);
            end
            n_assert++;
            if (press_cyc[2] - c0 !== 8) begin
                n_fail++;
                $display("FAIL long_press_latency_%0d: %0d cycles, expected 8", r, press_cyc[2] - c0);
            end
            n_assert++;
            if (long_cyc[2] - press_cyc[2] !== 50) begin
                n_fail++;
                $display("FAIL long_threshold_%0d: %0d cycles press->long, expected 50",
                         r, long_cyc[2] - press_cyc[2]);
            end
            n_assert++;
            if (toggle_o[2] !== exp_tog) begin
                n_fail++;
                $display("FAIL long_toggle_%0d: toggle_o[2]=%b, expected %b", r, toggle_o[2], exp_tog);
            end
            n_assert++;
            if (long_pend_o[2] !== 1'b1 || short_pend_o[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL long_pend_%0d: long/short pend %b/%b, expected 1/0",
                         r, long_pend_o[2], short_pend_o[2]);
            end
            ev_ack_i[2] = 1'b1;
            step(1);
            ev_ack_i[2] = 1'b0;
            n_assert++;
            if (long_pend_o[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL long_pend_ack_%0d: long_pend_o[2]=%b, expected 0", r, long_pend_o[2]);
            end
        end
    endtask

    //-------------------------------------------------------------------------
    task automatic test_ack_same_cycle();
        logic found;
        found = 1'b0;
        btn_i[2] = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            step(1);
            if (long_pulse_o[2] === 1'b1) found = 1'b1;
        end
        n_assert++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_wait_long: long_pulse_o[2] not seen within 80 cycles");
        end
        ev_ack_i[2] = 1'b1;
        step(1);
        ev_ack_i[2] = 1'b0;
        n_assert++;
        if (long_pend_o[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_same_cycle: long_pend_o[2]=%b, expected 1 (set beats ack)", long_pend_o[2]);
        end
        step(3);
        ev_ack_i[2] = 1'b1;
        step(1);
        ev_ack_i[2] = 1'b0;
        n_assert++;
        if (long_pend_o[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_later: long_pend_o[2]=%b, expected 0", long_pend_o[2]);
        end
        btn_i[2] = 1'b1;
        step(15);
        n_assert++;
        if (toggle_o[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_toggle: toggle_o[2]=%b after third long, expected 1", toggle_o[2]);
        end
    endtask

    //-------------------------------------------------------------------------
    task automatic test_autorepeat();
        logic found;
        int   n_rep, first, pp, sp, exp_rep, exp_first;
`ifdef GPI_EVENT_UNIT_AUTOREPEAT_EN
        exp_rep   = 10;
        exp_first = 10;
`else
        exp_rep   = 0;
        exp_first = -1;
`endif
        found = 1'b0;
        btn_i[3] = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            step(1);
            if (long_pulse_o[3] === 1'b1) found = 1'b1;
        end
        n_assert++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL rep_wait_long: long_pulse_o[3] not seen within 80 cycles");
        end
        n_rep = 0;
        first = -1;
        for (int i = 1; i <= 100; i++) begin
            step(1);
            if (press_pulse_o[3] === 1'b1) begin
                n_rep++;
                if (first < 0) first = i;
            end
        end
        n_assert++;
        if (n_rep !== exp_rep) begin
            n_fail++;
            $display("FAIL rep_count: %0d repeat pulses, expected %0d", n_rep, exp_rep);
        end
        n_assert++;
        if (first !== exp_first) begin
            n_fail++;
            $display("FAIL rep_first: first repeat at +%0d, expected +%0d", first, exp_first);
        end
        btn_i[3] = 1'b1;
        step(1);
        pp = press_cnt[3];
        sp = short_cnt[3];
        step(19);
        n_assert++;
        if (press_cnt[3] !== pp || short_cnt[3] !== sp) begin
            n_fail++;
            $display("FAIL rep_release: press/short +%0d/+%0d after release, expected +0/+0",
                     press_cnt[3] - pp, short_cnt[3] - sp);
        end
        n_assert++;
        if (long_pend_o[3] !== 1'b1 || short_pend_o[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL rep_pend: long/short pend %b/%b, expected 1/0", long_pend_o[3], short_pend_o[3]);
        end
    endtask

    //-------------------------------------------------------------------------
    task automatic test_reset_mid_press();
        int pp, sp;
        btn_i[0] = 1'b0;
        step(10);
        n_assert++;
        if (level_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre_level: level_o[0]=%b before reset, expected 1", level_o[0]);
        end
        #5;
        resetn = 1'b0;
        #1;
        n_assert++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL mid_async_clear: outputs %h right after reset, expected 0", all_outs());
        end
        step(2);
        resetn = 1'b1;
        pp = press_cnt[0];
        step(6);
        n_assert++;
        if (level_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_level_early: level_o[0]=%b 6 cycles after reset, expected 0", level_o[0]);
        end
        step(1);
        n_assert++;
        if (level_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_level_rise: level_o[0]=%b 7 cycles after reset, expected 1", level_o[0]);
        end
        step(1);
        n_assert++;
        if (press_pulse_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_press_pulse: press_pulse_o[0]=%b, expected 1", press_pulse_o[0]);
        end
        step(20);
        n_assert++;
        if (press_cnt[0] !== pp + 1) begin
            n_fail++;
            $display("FAIL mid_press_once: +%0d press pulses, expected +1", press_cnt[0] - pp);
        end
        sp = short_cnt[0];
        btn_i[0] = 1'b1;
        step(12);
        n_assert++;
        if (short_cnt[0] !== sp + 1 || short_pend_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_short: short +%0d pend %b, expected +1 pend 1",
                     short_cnt[0] - sp, short_pend_o[0]);
        end
    endtask

    //-------------------------------------------------------------------------
    initial begin
        resetn   = 1'b0;
        btn_i    = 4'hF;
        ev_ack_i = 4'h0;
        test_reset();
        test_glitch();
        test_short_press();
        test_long_press();
        test_ack_same_cycle();
        test_autorepeat();
        test_reset_mid_press();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
